// File: rtl/mult.sv
// Multi-cycle radix-2 Booth multiplier for MULT (signed) and MULTU (unsigned).
// Produces a 2*WIDTH-bit product into hi/lo after WIDTH+1 falling edges.
// All registers update on the falling edge of clk; rst is synchronous, active-high.
//
// Ports:
//   clk          clock (falling-edge active)
//   rst          synchronous active-high reset
//   mult_start   request a multiply; honoured only in IDLE
//   signed_op    1 = MULT, 0 = MULTU; sampled with mult_start
//   multiplicand operand A; sampled with mult_start
//   multiplier   operand B; sampled with mult_start
//   busy         high while an operation is in flight (RUN/FIX)
//   mult_end     completion flag, held until the next accepted start or reset
//   hi, lo       upper and lower halves of the product
module mult #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mult_start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             mult_end,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state, state_nx;
   logic [WIDTH:0]   m_q, m_nx;
   logic [WIDTH:0]   acc_q, acc_nx, acc_sum;
   logic [WIDTH-1:0] q_q, q_nx;
   logic             qm1_q, qm1_nx;
   logic             qmsb_q, qmsb_nx;
   logic             sgn_q, sgn_nx;
   logic [CW-1:0]    cnt_q, cnt_nx;
   logic             busy_nx, end_nx;
   logic [WIDTH-1:0] hi_nx, lo_nx;

   // Next-state, Booth datapath and output logic
   always_comb begin
      state_nx = state;
      m_nx     = m_q;
      acc_nx   = acc_q;
      acc_sum  = acc_q;
      q_nx     = q_q;
      qm1_nx   = qm1_q;
      qmsb_nx  = qmsb_q;
      sgn_nx   = sgn_q;
      cnt_nx   = cnt_q;
      busy_nx  = busy;
      end_nx   = mult_end;
      hi_nx    = hi;
      lo_nx    = lo;

      unique case (state)
         IDLE: begin
            if (mult_start) begin
               m_nx     = signed_op ? {multiplicand[WIDTH-1], multiplicand}
                                    : {1'b0, multiplicand};
               acc_nx   = '0;
               q_nx     = multiplier;
               qm1_nx   = 1'b0;
               qmsb_nx  = multiplier[WIDTH-1];
               sgn_nx   = signed_op;
               cnt_nx   = CW'(WIDTH);
               busy_nx  = 1'b1;
               end_nx   = 1'b0;
               state_nx = RUN;
            end
         end
         RUN: begin
            unique case ({q_q[0], qm1_q})
               2'b01:   acc_sum = acc_q + m_q;
               2'b10:   acc_sum = acc_q - m_q;
               default: acc_sum = acc_q;
            endcase
            // Arithmetic right shift of {Acc, Q, q_m1}
            acc_nx = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
            q_nx   = {acc_sum[0], q_q[WIDTH-1:1]};
            qm1_nx = q_q[0];
            cnt_nx = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_nx = FIX;
         end
         FIX: begin
            // Booth treated B as signed; MULTU with B[msb]=1 is short by M*2^WIDTH
            hi_nx    = (!sgn_q && qmsb_q) ? acc_q[WIDTH-1:0] + m_q[WIDTH-1:0]
                                          : acc_q[WIDTH-1:0];
            lo_nx    = q_q;
            end_nx   = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and output registers, falling-edge with synchronous reset
   always_ff @(negedge clk) begin
      if (rst) begin
         state    <= IDLE;
         m_q      <= '0;
         acc_q    <= '0;
         q_q      <= '0;
         qm1_q    <= 1'b0;
         qmsb_q   <= 1'b0;
         sgn_q    <= 1'b0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         mult_end <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         state    <= state_nx;
         m_q      <= m_nx;
         acc_q    <= acc_nx;
         q_q      <= q_nx;
         qm1_q    <= qm1_nx;
         qmsb_q   <= qmsb_nx;
         sgn_q    <= sgn_nx;
         cnt_q    <= cnt_nx;
         busy     <= busy_nx;
         mult_end <= end_nx;
         hi       <= hi_nx;
         lo       <= lo_nx;
      end
   end

endmodule

// File: tb/tb_mult.sv
// Testbench for mult: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed products and timing boundaries.
module tb_mult;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         mult_start;
   logic         signed_op;
   logic [W-1:0] multiplicand;
   logic [W-1:0] multiplier;
   logic         busy;
   logic         mult_end;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int checks   = 0;
   int failures = 0;

   mult #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .mult_start   (mult_start),
      .signed_op    (signed_op),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .mult_end     (mult_end),
      .hi           (hi),
      .lo           (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an operation is an exact product that appears WIDTH+1 edges after acceptance
   logic         m_valid = 1'b0;
   logic         m_busy, m_end;
   logic [W-1:0] m_hi, m_lo;
   logic [63:0]  m_prod;
   int           m_rem;

   always @(negedge clk) begin
      if (rst) begin
         m_valid = 1'b1;
         m_busy  = 1'b0;
         m_end   = 1'b0;
         m_hi    = '0;
         m_lo    = '0;
         m_rem   = 0;
      end else if (m_valid) begin
         if (!m_busy) begin
            if (mult_start) begin
               if (signed_op)
                  m_prod = 64'(longint'($signed(multiplicand)) * longint'($signed(multiplier)));
               else
                  m_prod = {32'b0, multiplicand} * {32'b0, multiplier};
               m_busy = 1'b1;
               m_end  = 1'b0;
               m_rem  = W + 1;
            end
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               m_busy = 1'b0;
               m_end  = 1'b1;
               m_hi   = m_prod[63:32];
               m_lo   = m_prod[31:0];
            end
         end
      end
   end

   // Compare on the rising edge, away from the active falling edge
   always @(posedge clk) begin
      if (m_valid) begin
         check("busy",     64'(busy),     64'(m_busy));
         check("mult_end", 64'(mult_end), 64'(m_end));
         check("hi",       64'(hi),       64'(m_hi));
         check("lo",       64'(lo),       64'(m_lo));
      end
   end

   task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      mult_start   = 1'b1;
      signed_op    = s;
      multiplicand = a;
      multiplier   = b;
   endtask

   // Issue one operation at a rising edge and check the result WIDTH+1 falling edges later
   task automatic run_op(input string name, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
      drive(s, a, b);
      @(posedge clk);
      mult_start = 1'b0;
      check({name, "_busy_run"}, 64'(busy), 64'(1));
      repeat (32) @(posedge clk);
      check({name, "_end_early"}, 64'(mult_end), 64'(0));
      @(posedge clk);
      check({name, "_end"},  64'(mult_end), 64'(1));
      check({name, "_busy"}, 64'(busy), 64'(0));
      check({name, "_hi"},   64'(hi), 64'(ehi));
      check({name, "_lo"},   64'(lo), 64'(elo));
   endtask

   initial begin
      rst          = 1'b1;
      mult_start   = 1'b0;
      signed_op    = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (2) @(posedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_end",  64'(mult_end), 64'(0));
      check("rst_hi",   64'(hi), 64'(0));
      check("rst_lo",   64'(lo), 64'(0));
      rst = 1'b0;
      @(posedge clk);

      run_op("s_mixed",  1'b1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("s_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run_op("s_maxmin", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
      run_op("u_ones",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("u_2xmsb",  1'b0, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000);
      run_op("s_posneg", 1'b1, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000);
      run_op("u_small",  1'b0, 32'd12345,     32'd6789,      32'h0000_0000, 32'd83810205);

      // Start while busy must be ignored
      drive(1'b0, 32'd3, 32'd5);
      @(posedge clk);
      mult_start = 1'b0;
      repeat (9) @(posedge clk);
      drive(1'b0, 32'd9, 32'd9);
      @(posedge clk);
      mult_start = 1'b0;
      repeat (22) @(posedge clk);
      check("busyprot_end_early", 64'(mult_end), 64'(0));
      @(posedge clk);
      check("busyprot_end", 64'(mult_end), 64'(1));
      check("busyprot_hi",  64'(hi), 64'(0));
      check("busyprot_lo",  64'(lo), 64'(15));
      repeat (2) @(posedge clk);

      // Reset mid-operation discards everything
      drive(1'b0, 32'd6, 32'd7);
      @(posedge clk);
      mult_start = 1'b0;
      repeat (11) @(posedge clk);
      rst = 1'b1;
      @(posedge clk);
      rst = 1'b0;
      check("rstmid_busy", 64'(busy), 64'(0));
      check("rstmid_end",  64'(mult_end), 64'(0));
      check("rstmid_hi",   64'(hi), 64'(0));
      check("rstmid_lo",   64'(lo), 64'(0));
      @(posedge clk);
      run_op("after_rst", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42);

      // Back-to-back with mult_start held high
      drive(1'b0, 32'd2, 32'd3);
      @(posedge clk);
      multiplicand = 32'd4;
      multiplier   = 32'd5;
      repeat (33) @(posedge clk);
      check("b2b_first_end", 64'(mult_end), 64'(1));
      check("b2b_first_lo",  64'(lo), 64'(6));
      @(posedge clk);
      mult_start = 1'b0;
      check("b2b_end_cleared", 64'(mult_end), 64'(0));
      check("b2b_busy",        64'(busy), 64'(1));
      repeat (33) @(posedge clk);
      check("b2b_second_end", 64'(mult_end), 64'(1));
      check("b2b_second_lo",  64'(lo), 64'(20));
      check("b2b_second_hi",  64'(hi), 64'(0));

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult.md
Name: mult

Overview:
- Multi-cycle radix-2 Booth multiplier for the MIPS datapath; implements MULT (signed) and MULTU (unsigned).
- Writes the 2*WIDTH-bit product into the hi/lo pair, mirroring how the divide unit feeds the same registers.
- Controlled by a start/end handshake from the control unit.
- All state updates on the falling edge of clk, matching the arithmetic units' timing against the control FSM.

Parameters:
- WIDTH, 32, operand width; hi and lo are WIDTH bits each.

Ports:
- clk  input  1  clock; all registers update on its falling edge.
- rst  input  1  synchronous active-high reset, sampled on the falling edge of clk.
- mult_start  input  1  request a multiply; honoured only in IDLE.
- signed_op  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with mult_start.
- multiplicand  input  WIDTH  operand A; sampled with mult_start.
- multiplier  input  WIDTH  operand B; sampled with mult_start.
- busy  output  1  high in RUN and FIX.
- mult_end  output  1  completion flag.
- hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
- lo  output  WIDTH  product bits [WIDTH-1:0].

Behaviour:
- Reset (rst=1 at a falling edge): state=IDLE; busy=0, mult_end=0, hi=0, lo=0; any in-flight operation is discarded. Reset has priority over everything.
- States: IDLE, RUN, FIX.
- IDLE, mult_start=1: load internal registers, clear mult_end, go to RUN, counter=WIDTH.
  - M = WIDTH+1 bits; sign-extended if signed_op, else zero-extended.
  - Acc = WIDTH+1 bits, set to 0.
  - Q = multiplier; q_m1 = 0.
  - Latch q_msb = multiplier[WIDTH-1] and signed_op.
- IDLE, mult_start=0: hold all state; hi, lo and mult_end keep their values.
- RUN, one Booth step per falling edge:
  - {Q[0],q_m1}=01: Acc += M.
  - {Q[0],q_m1}=10: Acc -= M.
  - 00 or 11: Acc unchanged.
  - Then arithmetic-shift {Acc,Q,q_m1} right by 1 (Acc MSB replicated).
  - counter decrements; after the WIDTH-th step go to FIX.
- FIX, one edge:
  - If MULTU and latched q_msb=1: hi = Acc[WIDTH-1:0] + M[WIDTH-1:0] (mod 2^WIDTH).
  - Otherwise hi = Acc[WIDTH-1:0].
  - lo = Q; mult_end=1; go to IDLE.
- Latency: start accepted at edge 0; hi/lo/mult_end valid after edge WIDTH+1 (33 for the default).
- mult_end stays high until the next accepted start (cleared on the accepting edge) or reset.
- hi/lo hold their previous results throughout RUN and FIX; they change only in FIX.
- mult_start while busy=1: ignored; no restart and no operand resample.
- mult_start held high continuously: a new operation is accepted on the first IDLE edge after FIX.
- Arithmetic is exact for all operand pairs, including most-negative values (e.g. -2^31 * -2^31).
- No overflow flag; all intermediate arithmetic wraps in WIDTH+1 bits.

Test Plan:
- Signed small mixed signs: signed_op=1, 7 * 0xFFFFFFFD -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB; mult_end=1 and busy=0 on that edge.
- Signed extremes: 0x80000000 * 0x80000000, signed_op=1 -> hi=0x40000000, lo=0x00000000; also 0x7FFFFFFF * 0x80000000 -> hi=0xC0000000, lo=0x80000000.
- Unsigned correction path: signed_op=0, 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; also 0x00000002 * 0x80000000 -> hi=0x00000001, lo=0x00000000.
- Busy protection: start 3*5; at edge 10 assert mult_start with 9*9 -> result hi=0, lo=15 at edge 33; mult_end stays 0 before edge 33.
- Reset mid-operation: start 6*7, assert rst at edge 12 -> busy=0, mult_end=0, hi=lo=0 next edge; a fresh 6*7 then yields lo=42 after 33 edges.
- Back-to-back with mult_start held high: 2*3 then 4*5 -> lo=6 at edge 33, mult_end cleared at edge 34, lo=20 at edge 67.
